// File: rtl/s_memory_fill_fsm.sv
// Scratch-RAM initialiser: sweeps 0..DEPTH-1, one write per word after a
// programmable settle period, with identity / constant / descending patterns.
module s_memory_fill_fsm #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 256,
  parameter int SETTLE_CYCLES = 1,
  parameter int AUTO_START    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic              AUTO       = (AUTO_START != 0);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  settle_cnt;
  logic [1:0]        mode_lat;
  logic [DATA_W-1:0] fill_lat;
  logic              auto_pending;
  logic              accept;
  logic              settle_end;
  logic              last_word;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] fv,
                                                input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] desc;
    desc = LAST_ADDR - a;
    case (m)
      2'd1:    return fv;
      2'd2:    return DATA_W'(desc);
      default: return DATA_W'(a);
    endcase
  endfunction

  // auto_pending marks only the first cycle after reset, so AUTO_START never re-arms from DONE
  assign accept = ((state == IDLE) || (state == DONE)) &&
                  (start || (AUTO && auto_pending && (state == IDLE)));
  assign settle_end = (settle_cnt == SETTLE_END);
  assign last_word  = (address == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      address      <= '0;
      data         <= '0;
      settle_cnt   <= '0;
      auto_pending <= 1'b1;
    end else begin
      state        <= state_nxt;
      auto_pending <= 1'b0;
      if (accept) begin
        mode_lat   <= mode;
        fill_lat   <= fill_value;
        address    <= '0;
        data       <= pattern(mode, fill_value, '0);
        settle_cnt <= '0;
      end else if (state == SETUP) begin
        settle_cnt <= settle_end ? '0 : settle_cnt + 1'b1;
      end else if ((state == WRITE) && !last_word) begin
        // stepping stops at LAST_ADDR, so the counter can never wrap
        address <= address + 1'b1;
        data    <= pattern(mode_lat, fill_lat, address + 1'b1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = SETUP;
      SETUP:      if (settle_end) state_nxt = WRITE;
      WRITE:      state_nxt = last_word ? DONE : SETUP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wren = (state == WRITE);
    busy = (state == SETUP) || (state == WRITE);
    done = (state == DONE);
  end

endmodule
